// File: rtl/calc_pkg.sv
// Shared constants and types for the arithmetic result path.
// Provides the default adder result width, BCD nibble geometry, the
// double-dabble correction threshold and the converter state encoding.
package calc_pkg;

    localparam int IN_W_DEF       = 14;
    localparam int BCD_NIBBLE_W   = 4;
    localparam int ADD3_THRESHOLD = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage : calc_pkg

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction for one BCD digit: a nibble of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
// Ports:
//   nib_i - BCD nibble before correction
//   nib_o - corrected nibble
module bcd_add3_nibble
    import calc_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] nib_i,
    output logic [BCD_NIBBLE_W-1:0] nib_o
);

    // Conditional +3 correction.
    always_comb begin
        if (nib_i >= BCD_NIBBLE_W'(ADD3_THRESHOLD)) begin
            nib_o = nib_i + BCD_NIBBLE_W'(3);
        end else begin
            nib_o = nib_i;
        end
    end

endmodule : bcd_add3_nibble

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter for the adder result.
// One conversion takes IN_W+2 cycles: load, IN_W shift cycles, finish.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset, aborts a conversion
//   start     - conversion request, honoured only in IDLE
//   is_signed - interpret bin as two's complement (sampled with start)
//   bin       - value to convert (sampled with start)
//   busy      - high while the conversion is in progress
//   done      - one-cycle pulse when bcd/neg/ovf are updated
//   bcd       - packed BCD result, digit 0 in bits [3:0]
//   neg       - result is negative
//   ovf       - a digit beyond the displayable ones is nonzero
module bin_to_bcd_seq
    import calc_pkg::*;
#(
    parameter int IN_W        = IN_W_DEF,
    parameter int DIGITS      = 5,
    parameter int DISP_DIGITS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             is_signed,
    input  logic [IN_W-1:0]                  bin,
    output logic                             busy,
    output logic                             done,
    output logic [BCD_NIBBLE_W*DIGITS-1:0]   bcd,
    output logic                             neg,
    output logic                             ovf
);

    localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int SCR_W = BCD_W + IN_W;
    localparam int CNT_W = $clog2(IN_W);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic               neg_pending_q, neg_pending_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;

    logic [IN_W-1:0]    mag_s;
    logic               sign_s;
    logic [BCD_W-1:0]   adj_bcd_s;
    logic               ovf_s;

    // Per-digit +3 correction of the BCD field ahead of each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_nibble u_add3 (
            .nib_i (scratch_q[IN_W + BCD_NIBBLE_W*g +: BCD_NIBBLE_W]),
            .nib_o (adj_bcd_s[BCD_NIBBLE_W*g +: BCD_NIBBLE_W])
        );
    end

    // Input magnitude and sign; the most negative value maps to 2^(IN_W-1)
    // read as unsigned, and a zero magnitude is never reported negative.
    always_comb begin
        sign_s = is_signed & bin[IN_W-1];
        if (sign_s) begin
            mag_s = ~bin + IN_W'(1);
        end else begin
            mag_s = bin;
        end
    end

    // Overflow: any nonzero digit the display cannot show.
    always_comb begin
        ovf_s = 1'b0;
        for (int i = DISP_DIGITS; i < DIGITS; i++) begin
            ovf_s = ovf_s | (scratch_q[IN_W + BCD_NIBBLE_W*i +: BCD_NIBBLE_W] != BCD_NIBBLE_W'(0));
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        scratch_d     = scratch_q;
        neg_pending_d = neg_pending_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        bcd_d         = bcd_q;
        neg_d         = neg_q;
        ovf_d         = ovf_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    scratch_d     = {{BCD_W{1'b0}}, mag_s};
                    neg_pending_d = sign_s & (mag_s != IN_W'(0));
                    cnt_d         = CNT_W'(0);
                    state_d       = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                busy_d    = 1'b1;
                // The top bit of the corrected field is always zero, so
                // dropping it in the shift loses nothing.
                scratch_d = {adj_bcd_s, scratch_q[IN_W-1:0]} << 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    state_d = FINISH;
                end else begin
                    state_d = SHIFT;
                end
            end
            FINISH: begin
                bcd_d   = scratch_q[SCR_W-1:IN_W];
                neg_d   = neg_pending_q;
                ovf_d   = ovf_s;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_W'(0);
            scratch_q     <= SCR_W'(0);
            neg_pending_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            bcd_q         <= BCD_W'(0);
            neg_q         <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            scratch_q     <= scratch_d;
            neg_pending_q <= neg_pending_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            bcd_q         <= bcd_d;
            neg_q         <= neg_d;
            ovf_q         <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed scenarios plus random
// conversions compared against an arithmetic decimal-digit model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [13:0] bin = 14'd0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;

    int n_checks = 0;
    int n_fails  = 0;

    logic [19:0] last_bcd = 20'h0;

    logic [13:0] kv_bin [0:3] = '{14'd9801, 14'd16383, 14'h3FFF, 14'h2000};
    logic        kv_sg  [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [19:0] kv_bcd [0:3] = '{20'h09801, 20'h16383, 20'h00001, 20'h08192};
    logic        kv_neg [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        kv_ovf [0:3] = '{1'b0, 1'b1, 1'b0, 1'b0};

    bin_to_bcd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .neg       (neg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal digits by repeated division.
    function automatic logic [19:0] ref_bcd(input int m);
        logic [19:0] r;
        int v;
        r = 20'h0;
        v = m;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int ref_mag(input logic [13:0] b, input logic sg);
        if (sg && b[13]) return 16384 - int'(b);
        return int'(b);
    endfunction

    task automatic do_start(input logic [13:0] b, input logic sg);
        bin       = b;
        is_signed = sg;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Edges from the start edge until done is seen (-1 if never seen).
    task automatic wait_done(input int max, output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (1) begin
            tick();
            edges++;
            if (busy) busy_cnt++;
            if (done) return;
            if (edges >= max) begin
                edges = -1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, neg, ovf} !== 4'b0000) begin
            n_fails++;
            $display("FAIL reset_flags: busy/done/neg/ovf=%b required 0000", {busy, done, neg, ovf});
        end
        n_checks++;
        if (bcd !== 20'h0) begin
            n_fails++;
            $display("FAIL reset_bcd: got %h required 00000", bcd);
        end
    endtask

    task automatic test_zero_latency();
        int e, bc;
        do_start(14'd0, 1'b0);
        wait_done(40, e, bc);
        n_checks++;
        if (e !== 15) begin
            n_fails++;
            $display("FAIL zero_latency: done after %0d edges required 15", e);
        end
        n_checks++;
        if (bc !== 14) begin
            n_fails++;
            $display("FAIL zero_busy_cycles: got %0d required 14", bc);
        end
        n_checks++;
        if ({bcd, neg, ovf} !== {20'h0, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL zero_result: bcd=%h neg=%b ovf=%b required 00000 0 0", bcd, neg, ovf);
        end
        last_bcd = 20'h0;
    endtask

    task automatic test_known_values();
        int e, bc;
        for (int i = 0; i < 4; i++) begin
            do_start(kv_bin[i], kv_sg[i]);
            wait_done(40, e, bc);
            n_checks++;
            if (e !== 15 || bcd !== kv_bcd[i] || neg !== kv_neg[i] || ovf !== kv_ovf[i]) begin
                n_fails++;
                $display("FAIL known_%0d: edges=%0d bcd=%h neg=%b ovf=%b required 15 %h %b %b",
                         i, e, bcd, neg, ovf, kv_bcd[i], kv_neg[i], kv_ovf[i]);
            end
            last_bcd = kv_bcd[i];
            tick();
        end
    endtask

    task automatic test_random();
        int e, bc, m;
        logic [13:0] b;
        logic sg;
        logic [19:0] eb;
        for (int i = 0; i < 24; i++) begin
            b  = 14'($urandom_range(0, 16383));
            if (i == 0) b = 14'd9999;
            if (i == 1) b = 14'd10000;
            sg = 1'($urandom_range(0, 1));
            m  = ref_mag(b, sg);
            eb = ref_bcd(m);
            do_start(b, sg);
            wait_done(40, e, bc);
            n_checks++;
            if (e !== 15 || bcd !== eb || neg !== (sg && b[13]) || ovf !== (m > 9999)) begin
                n_fails++;
                $display("FAIL random_%0d bin=%h signed=%b: edges=%0d bcd=%h neg=%b ovf=%b required 15 %h %b %b",
                         i, b, sg, e, bcd, neg, ovf, eb, sg && b[13], m > 9999);
            end
            last_bcd = eb;
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        int held_bad = 0;
        logic [19:0] prev;
        prev = last_bcd;
        do_start(14'd255, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            if (i == 3 || i == 15) begin
                bin   = 14'd1;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done) dones++;
            if (i < 15 && bcd !== prev) held_bad++;
        end
        n_checks++;
        if (dones !== 1) begin
            n_fails++;
            $display("FAIL ignore_start_dones: got %0d required 1", dones);
        end
        n_checks++;
        if (held_bad !== 0) begin
            n_fails++;
            $display("FAIL ignore_start_hold: %0d cycles changed, required 0", held_bad);
        end
        n_checks++;
        if (bcd !== 20'h00255) begin
            n_fails++;
            $display("FAIL ignore_start_bcd: got %h required 00255", bcd);
        end
        last_bcd = 20'h00255;
    endtask

    task automatic test_reset_abort();
        int e, bc;
        int dones = 0;
        do_start(14'd1234, 1'b0);
        wait_done(40, e, bc);
        n_checks++;
        if (bcd !== 20'h01234) begin
            n_fails++;
            $display("FAIL abort_pre_bcd: got %h required 01234", bcd);
        end
        tick();
        do_start(14'd5678, 1'b0);
        for (int i = 1; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, neg, ovf} !== 4'b0000 || bcd !== 20'h0) begin
            n_fails++;
            $display("FAIL abort_clear: busy=%b done=%b bcd=%h neg=%b ovf=%b required all zero",
                     busy, done, bcd, neg, ovf);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fails++;
            $display("FAIL abort_no_done: got %0d done pulses required 0", dones);
        end
        do_start(14'd42, 1'b0);
        wait_done(40, e, bc);
        n_checks++;
        if (e !== 15 || bcd !== 20'h00042) begin
            n_fails++;
            $display("FAIL abort_restart: edges=%0d bcd=%h required 15 00042", e, bcd);
        end
        last_bcd = 20'h00042;
        tick();
    endtask

    task automatic test_back_to_back();
        int e, bc, n;
        int held_bad = 0;
        logic [19:0] eb_a, eb_b;
        eb_a = ref_bcd(7777);
        eb_b = ref_bcd(3141);
        do_start(14'd7777, 1'b0);
        wait_done(40, e, bc);
        n_checks++;
        if (bcd !== eb_a) begin
            n_fails++;
            $display("FAIL b2b_first: got %h required %h", bcd, eb_a);
        end
        do_start(14'd3141, 1'b0);
        n = 1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_done_width: done=%b one cycle later required 0", done);
        end
        while (!done && n < 40) begin
            if (bcd !== eb_a) held_bad++;
            tick();
            n++;
        end
        n_checks++;
        if (n !== 16) begin
            n_fails++;
            $display("FAIL b2b_spacing: %0d edges between dones required 16", n);
        end
        n_checks++;
        if (held_bad !== 0) begin
            n_fails++;
            $display("FAIL b2b_hold: %0d cycles changed early, required 0", held_bad);
        end
        n_checks++;
        if (bcd !== eb_b) begin
            n_fails++;
            $display("FAIL b2b_second: got %h required %h", bcd, eb_b);
        end
        last_bcd = eb_b;
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        tick();
        test_known_values();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
